// File: rtl/boot_imem_pkg.sv
// Shared constants, FSM state encoding and helpers for the boot loader / program memory.
package boot_imem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 128;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_LEN = 2'd0,
        S_LO  = 2'd1,
        S_HI  = 2'd2,
        S_RUN = 2'd3
    } state_t;

    // Length bytes above the store size are clamped so a load can never write past the last word.
    function automatic logic [CNT_W-1:0] sat_len(input logic [BYTE_W-1:0] len_byte);
        if (int'(len_byte) > DEPTH) begin
            return CNT_W'(DEPTH);
        end
        return CNT_W'(len_byte);
    endfunction

endpackage

// File: rtl/boot_imem_imem.sv
// Word store: one synchronous write port, one asynchronous read port, contents survive reset.
module boot_imem_imem #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; deliberately no reset so a reset mid-load keeps whatever was already stored.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/boot_imem.sv
// Boot loader and program memory: takes a length byte plus little-endian word pairs from a
// valid/ready byte stream while holding the core in reset, then releases it and serves fetches.
module boot_imem
    import boot_imem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              boot,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              cpu_reset,
    output logic              load_done,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [BYTE_W-1:0]  lo_q;
    logic [BYTE_W-1:0]  lo_nxt;
    logic               accept;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;

    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign word_cnt = cnt_q;

    // State register; cpu_reset/load_done are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LEN;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_reset <= (state_nxt != S_RUN);
            load_done <= (state_nxt == S_RUN);
        end
    end

    // Next-state logic: length byte, then low/high pairs until the requested word count is reached.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN: begin
                if (accept) begin
                    state_nxt = (in_data == '0) ? S_RUN : S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_nxt = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    state_nxt = (cnt_inc == len_q) ? S_RUN : S_LO;
                end
            end
            S_RUN: begin
                if (boot) begin
                    state_nxt = S_LEN;
                end
            end
            default: begin
                state_nxt = S_LEN;
            end
        endcase
    end

    // Output and datapath control; a write coinciding with reset is dropped so reset fully wins.
    always_comb begin
        in_ready = (state != S_RUN);
        wr_en    = accept & (state == S_HI) & ~reset;
        wr_data  = {in_data, lo_q};
        len_nxt  = len_q;
        cnt_nxt  = cnt_q;
        lo_nxt   = lo_q;
        if (accept) begin
            case (state)
                S_LEN: begin
                    len_nxt = sat_len(in_data);
                    cnt_nxt = '0;
                end
                S_LO: begin
                    lo_nxt = in_data;
                end
                S_HI: begin
                    cnt_nxt = cnt_inc;
                end
                default: begin
                    len_nxt = len_q;
                end
            endcase
        end
    end

    // Length, word counter and low-byte hold; word_cnt survives a boot request until the next length byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
            cnt_q <= '0;
            lo_q  <= '0;
        end else begin
            len_q <= len_nxt;
            cnt_q <= cnt_nxt;
            lo_q  <= lo_nxt;
        end
    end

    boot_imem_imem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_imem (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (cnt_q[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_boot_imem.sv
// Testbench for boot_imem: stream-level model of the loader plus literal spot checks.
module tb_boot_imem;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        boot;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;
    logic        cpu_reset;
    logic        load_done;
    logic [7:0]  word_cnt;

    int checks   = 0;
    int failures = 0;

    // Model state: loader phase as byte counts rather than an FSM.
    bit          model_valid = 0;
    bit          m_running   = 0;
    int          m_got       = -1;
    int          m_len       = 0;
    int          m_cnt       = 0;
    logic [7:0]  m_lo        = 8'h00;
    logic [15:0] m_mem   [128];
    bit          m_known [128];

    boot_imem dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .boot      (boot),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Sends one byte, waiting (bounded) for in_ready, then idles for gap cycles.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("ready_timeout", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic readCheck(input string name, input logic [6:0] addr, input logic [15:0] exp);
        rd_addr = addr;
        #1;
        checkOutput(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic pulseBoot();
        boot = 1'b1;
        @(negedge clk);
        boot = 1'b0;
    endtask

    task automatic sendStream(input int gap);
        logic [7:0] bytes [7];
        bytes = '{8'h03, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                checkOutput("cpu_reset_before_last", 32'(cpu_reset), 32'd1);
            end
            applyStimulus(bytes[i], (i == 6) ? 0 : gap);
        end
    endtask

    // Reference model: interprets the accepted byte stream at each rising edge.
    initial begin
        for (int i = 0; i < 128; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                model_valid = 1'b1;
                m_running   = 1'b0;
                m_got       = -1;
                m_cnt       = 0;
            end else if (model_valid) begin
                if (m_running) begin
                    if (boot) begin
                        m_running = 1'b0;
                        m_got     = -1;
                    end
                end else if (in_valid) begin
                    if (m_got < 0) begin
                        m_cnt = 0;
                        if (in_data == 8'd0) begin
                            m_running = 1'b1;
                        end else begin
                            m_len = (int'(in_data) > 128) ? 128 : int'(in_data);
                            m_got = 0;
                        end
                    end else if (m_got % 2 == 0) begin
                        m_lo  = in_data;
                        m_got = m_got + 1;
                    end else begin
                        m_mem[m_cnt]   = {in_data, m_lo};
                        m_known[m_cnt] = 1'b1;
                        m_cnt = m_cnt + 1;
                        m_got = m_got + 1;
                        if (m_cnt == m_len) begin
                            m_running = 1'b1;
                            m_got     = -1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_valid) begin
                checkOutput("in_ready", 32'(in_ready), 32'(!m_running));
                checkOutput("cpu_reset", 32'(cpu_reset), 32'(!m_running));
                checkOutput("load_done", 32'(load_done), 32'(m_running));
                checkOutput("word_cnt", 32'(word_cnt), 32'(m_cnt));
                if (m_known[rd_addr]) begin
                    checkOutput("rd_data", 32'(rd_data), 32'(m_mem[rd_addr]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        boot     = 1'b0;
        rd_addr  = 7'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] back-to-back len=3 load");
        sendStream(0);
        checkOutput("load1_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("load1_load_done", 32'(load_done), 32'd1);
        checkOutput("load1_word_cnt", 32'(word_cnt), 32'd3);
        readCheck("load1_mem0", 7'd0, 16'h1234);
        readCheck("load1_mem1", 7'd1, 16'h5678);
        readCheck("load1_mem2", 7'd2, 16'h9ABC);

        $display("[TB] bytes offered while running are ignored");
        @(negedge clk);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("run_ignore_cnt", 32'(word_cnt), 32'd3);

        $display("[TB] reload with stalled stream");
        pulseBoot();
        checkOutput("boot_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("boot_keeps_cnt", 32'(word_cnt), 32'd3);
        rd_addr = 7'd1;
        sendStream(1);
        checkOutput("load2_word_cnt", 32'(word_cnt), 32'd3);
        readCheck("load2_mem0", 7'd0, 16'h1234);
        readCheck("load2_mem2", 7'd2, 16'h9ABC);

        $display("[TB] zero-length load");
        @(negedge clk);
        pulseBoot();
        applyStimulus(8'h00, 0);
        checkOutput("len0_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("len0_load_done", 32'(load_done), 32'd1);
        checkOutput("len0_word_cnt", 32'(word_cnt), 32'd0);
        readCheck("len0_mem0", 7'd0, 16'h1234);

        $display("[TB] oversize length saturates");
        @(negedge clk);
        pulseBoot();
        rd_addr = 7'd127;
        applyStimulus(8'd200, 0);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'(i), 0);
        end
        checkOutput("full_word_cnt", 32'(word_cnt), 32'd128);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        readCheck("full_mem127", 7'd127, 16'hFFFE);
        readCheck("full_mem0", 7'd0, 16'h0100);
        readCheck("full_mem64", 7'd64, 16'h8180);

        $display("[TB] reload single word");
        @(negedge clk);
        rd_addr = 7'd0;
        pulseBoot();
        checkOutput("boot2_cpu_reset", 32'(cpu_reset), 32'd1);
        applyStimulus(8'h01, 0);
        applyStimulus(8'hFF, 0);
        checkOutput("one_cpu_reset_mid", 32'(cpu_reset), 32'd1);
        applyStimulus(8'h00, 0);
        checkOutput("one_cpu_reset", 32'(cpu_reset), 32'd0);
        readCheck("one_mem0", 7'd0, 16'h00FF);
        readCheck("one_mem1", 7'd1, 16'h0302);

        $display("[TB] reset during a load");
        @(negedge clk);
        pulseBoot();
        applyStimulus(8'h04, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        readCheck("midrst_mem0", 7'd0, 16'h2211);
        readCheck("midrst_mem1", 7'd1, 16'h0302);
        @(negedge clk);
        applyStimulus(8'h01, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        checkOutput("final_word_cnt", 32'(word_cnt), 32'd1);
        checkOutput("final_load_done", 32'(load_done), 32'd1);
        readCheck("final_mem0", 7'd0, 16'hBBAA);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
